// File: rtl/score_board_if.sv
// score_board_if: game-side and pixel-side signals of the score keeper and overlay
interface score_board_if #(
   parameter int X_POS_W = 10,
   parameter int Y_POS_W = 9
);
   logic               frame_tick_i;
   logic [X_POS_W-1:0] ball_x_i;
   logic               restart_i;
   logic [X_POS_W-1:0] pixel_x_i;
   logic [Y_POS_W-1:0] pixel_y_i;
   logic               visible_range_i;
   logic [2:0]         rgb_i;
   logic [2:0]         rgb_o;
   logic [3:0]         pc_score_o;
   logic [3:0]         player_score_o;
   logic               game_over_o;
   logic               winner_o;
   modport master (
      output frame_tick_i, ball_x_i, restart_i, pixel_x_i, pixel_y_i, visible_range_i, rgb_i,
      input  rgb_o, pc_score_o, player_score_o, game_over_o, winner_o
   );
   modport slave (
      input  frame_tick_i, ball_x_i, restart_i, pixel_x_i, pixel_y_i, visible_range_i, rgb_i,
      output rgb_o, pc_score_o, player_score_o, game_over_o, winner_o
   );
endinterface

// File: rtl/score_board.sv
// score_board: pong score keeping per frame plus score digit and centre net overlay on the RGB stream
module score_board #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int X_POS_W    = 10,
   parameter int Y_POS_W    = 9,
   parameter int WIN_SCORE  = 9,
   parameter int SCALE_LOG2 = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   score_board_if.slave sb
);
   localparam int S     = 1 << SCALE_LOG2;
   localparam int PC_X0 = H_RES / 2 - 5 * S;
   localparam int PL_X0 = H_RES / 2 + 2 * S;
   localparam int TOP   = 16;
   localparam logic [X_POS_W-1:0] X_HRES  = X_POS_W'(H_RES);
   localparam logic [X_POS_W-1:0] X_QTR   = X_POS_W'(H_RES / 4);
   localparam logic [X_POS_W-1:0] X_3QTR  = X_POS_W'(3 * H_RES / 4);
   localparam logic [X_POS_W-1:0] X_HALF  = X_POS_W'(H_RES / 2);
   localparam logic [Y_POS_W-1:0] Y_VRES  = Y_POS_W'(V_RES);
   localparam logic [X_POS_W:0]   X_PC0   = (X_POS_W+1)'(PC_X0);
   localparam logic [X_POS_W:0]   X_PL0   = (X_POS_W+1)'(PL_X0);
   localparam logic [Y_POS_W:0]   Y_TOP   = (Y_POS_W+1)'(TOP);
   localparam logic [X_POS_W:0]   COLS    = (X_POS_W+1)'(3);
   localparam logic [Y_POS_W:0]   ROWS    = (Y_POS_W+1)'(5);
   localparam logic [3:0]         WIN     = 4'(WIN_SCORE);

   typedef enum logic {PLAY, OVER} state_e;

   state_e      state_q, state_d;
   logic        armed_q, armed_d;
   logic        winner_q, winner_d;
   logic [3:0]  pc_score_q, pc_score_d;
   logic [3:0]  player_score_q, player_score_d;
   logic [4:0]  blink_q, blink_d;
   logic [2:0]  rgb_q, rgb_d;

   logic             pc_goal, pl_goal, centre;
   logic [3:0]       pc_inc, pl_inc;
   logic [X_POS_W:0] dx_pc, dx_pl, col_pc, col_pl;
   logic [Y_POS_W:0] dy, row;
   logic             row_ok, pc_show, pl_show, pc_lit, pl_lit, net_lit;

   // 3x5 glyph lookup: rows top to bottom, MSB of each row is the left column
   function automatic logic glyph_px(input logic [3:0] d, input logic [2:0] r, input logic [1:0] c);
      logic [14:0] g;
      logic [3:0]  idx;
      case (d)
         4'd0:    g = 15'b111_101_101_101_111;
         4'd1:    g = 15'b010_110_010_010_111;
         4'd2:    g = 15'b111_001_111_100_111;
         4'd3:    g = 15'b111_001_111_001_111;
         4'd4:    g = 15'b101_101_111_001_001;
         4'd5:    g = 15'b111_100_111_001_111;
         4'd6:    g = 15'b111_100_111_101_111;
         4'd7:    g = 15'b111_001_001_001_001;
         4'd8:    g = 15'b111_101_111_101_111;
         4'd9:    g = 15'b111_101_111_001_111;
         default: g = '0;
      endcase
      idx = 4'(r) * 4'd3 + 4'(c);
      return g[4'd14 - idx];
   endfunction

   assign pc_goal = sb.ball_x_i > X_HRES;
   assign pl_goal = sb.ball_x_i == '0;
   assign centre  = (sb.ball_x_i >= X_QTR) && (sb.ball_x_i < X_3QTR);
   assign pc_inc  = pc_score_q + 4'd1;
   assign pl_inc  = player_score_q + 4'd1;

   // Per-frame scoring FSM; armed gives one point per exit until the ball returns to the middle half
   always_comb begin
      state_d        = state_q;
      armed_d        = armed_q;
      winner_d       = winner_q;
      pc_score_d     = pc_score_q;
      player_score_d = player_score_q;
      blink_d        = blink_q;
      if (sb.frame_tick_i) begin
         blink_d = blink_q + 5'd1;
         if (sb.restart_i) begin
            pc_score_d     = '0;
            player_score_d = '0;
            armed_d        = 1'b1;
            winner_d       = 1'b0;
            state_d        = PLAY;
         end else if (state_q == PLAY) begin
            if (armed_q && pc_goal) begin
               pc_score_d = pc_inc;
               armed_d    = 1'b0;
               if (pc_inc == WIN) begin
                  state_d  = OVER;
                  winner_d = 1'b0;
               end
            end else if (armed_q && pl_goal) begin
               player_score_d = pl_inc;
               armed_d        = 1'b0;
               if (pl_inc == WIN) begin
                  state_d  = OVER;
                  winner_d = 1'b1;
               end
            end else if (centre) begin
               armed_d = 1'b1;
            end
         end
      end
   end

   assign dx_pc  = {1'b0, sb.pixel_x_i} - X_PC0;
   assign dx_pl  = {1'b0, sb.pixel_x_i} - X_PL0;
   assign dy     = {1'b0, sb.pixel_y_i} - Y_TOP;
   assign col_pc = dx_pc >> SCALE_LOG2;
   assign col_pl = dx_pl >> SCALE_LOG2;
   assign row    = dy >> SCALE_LOG2;

   // Overlay: negative offsets are outside a glyph; the winner's digit blinks while the game is over
   always_comb begin
      row_ok  = !dy[Y_POS_W] && (row < ROWS);
      pc_show = !(state_q == OVER && !winner_q && blink_q[4]);
      pl_show = !(state_q == OVER && winner_q && blink_q[4]);
      pc_lit  = pc_show && row_ok && !dx_pc[X_POS_W] && (col_pc < COLS) &&
                glyph_px(pc_score_q, row[2:0], col_pc[1:0]);
      pl_lit  = pl_show && row_ok && !dx_pl[X_POS_W] && (col_pl < COLS) &&
                glyph_px(player_score_q, row[2:0], col_pl[1:0]);
      net_lit = (sb.pixel_x_i == X_HALF - 1'b1 || sb.pixel_x_i == X_HALF) &&
                !sb.pixel_y_i[3] && (sb.pixel_y_i < Y_VRES);
      rgb_d   = !sb.visible_range_i ? 3'b000 : (pc_lit || pl_lit || net_lit) ? 3'b111 : sb.rgb_i;
   end

   // State and pixel registers with asynchronous clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= PLAY;
         armed_q        <= 1'b1;
         winner_q       <= 1'b0;
         pc_score_q     <= '0;
         player_score_q <= '0;
         blink_q        <= '0;
         rgb_q          <= '0;
      end else begin
         state_q        <= state_d;
         armed_q        <= armed_d;
         winner_q       <= winner_d;
         pc_score_q     <= pc_score_d;
         player_score_q <= player_score_d;
         blink_q        <= blink_d;
         rgb_q          <= rgb_d;
      end
   end

   assign sb.rgb_o          = rgb_q;
   assign sb.pc_score_o     = pc_score_q;
   assign sb.player_score_o = player_score_q;
   assign sb.game_over_o    = state_q == OVER;
   assign sb.winner_o       = winner_q;
endmodule

// File: tb/tb_score_board.sv
// tb_score_board: table-driven scoring and pixel vectors with a queue scoreboard
module tb_score_board;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   score_board_if #(.X_POS_W(10), .Y_POS_W(9)) sb_if ();
   score_board dut (.clk_i(clk), .rst_ni(rst_n), .sb(sb_if));

   typedef struct {
      logic [9:0] bx;
      logic       rs;
      logic [3:0] pc;
      logic [3:0] pl;
      logic       ov;
      logic       wn;
   } tick_vec_t;

   typedef struct {
      logic [9:0] x;
      logic [8:0] y;
      logic       vis;
      logic [2:0] rgb;
      logic [2:0] exp;
   } pix_vec_t;

   tick_vec_t  tq[$];
   logic [2:0] pq[$];
   tick_vec_t  tv[17];
   pix_vec_t   pv[17];
   int         n_checks = 0;
   int         n_fail = 0;
   logic [4:0] tick_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic tick_vec_t tk(input logic [9:0] bx, input logic rs, input logic [3:0] pc,
                                    input logic [3:0] pl, input logic ov, input logic wn);
      tick_vec_t v;
      v.bx = bx; v.rs = rs; v.pc = pc; v.pl = pl; v.ov = ov; v.wn = wn;
      return v;
   endfunction

   task automatic do_tick(input tick_vec_t v, input string tag);
      tick_vec_t e;
      @(negedge clk);
      sb_if.ball_x_i     = v.bx;
      sb_if.restart_i    = v.rs;
      sb_if.frame_tick_i = 1'b1;
      tq.push_back(v);
      @(posedge clk);
      #1;
      tick_cnt++;
      sb_if.frame_tick_i = 1'b0;
      sb_if.restart_i    = 1'b0;
      e = tq.pop_front();
      check({tag, " pc_score"}, 32'(sb_if.pc_score_o), 32'(e.pc));
      check({tag, " player_score"}, 32'(sb_if.player_score_o), 32'(e.pl));
      check({tag, " game_over"}, 32'(sb_if.game_over_o), 32'(e.ov));
      if (e.ov) check({tag, " winner"}, 32'(sb_if.winner_o), 32'(e.wn));
   endtask

   task automatic pix_chk(input pix_vec_t v, input string tag);
      @(negedge clk);
      sb_if.pixel_x_i       = v.x;
      sb_if.pixel_y_i       = v.y;
      sb_if.visible_range_i = v.vis;
      sb_if.rgb_i           = v.rgb;
      pq.push_back(v.exp);
      @(posedge clk);
      #1;
      check(tag, 32'(sb_if.rgb_o), 32'(pq.pop_front()));
   endtask

   function automatic pix_vec_t px(input logic [9:0] x, input logic [8:0] y, input logic vis,
                                   input logic [2:0] rgb, input logic [2:0] exp);
      pix_vec_t v;
      v.x = x; v.y = y; v.vis = vis; v.rgb = rgb; v.exp = exp;
      return v;
   endfunction

   initial begin
      tv[0]  = tk(10'd0,   1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
      tv[1]  = tk(10'd0,   1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
      tv[2]  = tk(10'd0,   1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
      tv[3]  = tk(10'd320, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
      tv[4]  = tk(10'd700, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0);
      tv[5]  = tk(10'd641, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0);
      tv[6]  = tk(10'd640, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0);
      tv[7]  = tk(10'd160, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0);
      tv[8]  = tk(10'd641, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0);
      tv[9]  = tk(10'd480, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0);
      tv[10] = tk(10'd0,   1'b0, 4'd2, 4'd1, 1'b0, 1'b0);
      tv[11] = tk(10'd479, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0);
      tv[12] = tk(10'd0,   1'b0, 4'd2, 4'd2, 1'b0, 1'b0);
      tv[13] = tk(10'd320, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
      tv[14] = tk(10'd0,   1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
      tv[15] = tk(10'd0,   1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
      tv[16] = tk(10'd320, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);

      pv[0]  = px(10'd280, 9'd16,  1'b1, 3'b010, 3'b111);
      pv[1]  = px(10'd288, 9'd24,  1'b1, 3'b010, 3'b010);
      pv[2]  = px(10'd319, 9'd0,   1'b1, 3'b010, 3'b111);
      pv[3]  = px(10'd319, 9'd8,   1'b1, 3'b010, 3'b010);
      pv[4]  = px(10'd320, 9'd0,   1'b1, 3'b010, 3'b111);
      pv[5]  = px(10'd321, 9'd0,   1'b1, 3'b010, 3'b010);
      pv[6]  = px(10'd279, 9'd16,  1'b1, 3'b010, 3'b010);
      pv[7]  = px(10'd303, 9'd16,  1'b1, 3'b010, 3'b111);
      pv[8]  = px(10'd304, 9'd16,  1'b1, 3'b010, 3'b010);
      pv[9]  = px(10'd280, 9'd55,  1'b1, 3'b010, 3'b111);
      pv[10] = px(10'd280, 9'd56,  1'b1, 3'b010, 3'b010);
      pv[11] = px(10'd336, 9'd16,  1'b1, 3'b010, 3'b010);
      pv[12] = px(10'd344, 9'd16,  1'b1, 3'b010, 3'b111);
      pv[13] = px(10'd336, 9'd24,  1'b1, 3'b010, 3'b111);
      pv[14] = px(10'd280, 9'd16,  1'b0, 3'b010, 3'b000);
      pv[15] = px(10'd100, 9'd100, 1'b0, 3'b101, 3'b000);
      pv[16] = px(10'd100, 9'd100, 1'b1, 3'b101, 3'b101);

      sb_if.frame_tick_i    = 1'b0;
      sb_if.ball_x_i        = 10'd320;
      sb_if.restart_i       = 1'b0;
      sb_if.pixel_x_i       = 10'd280;
      sb_if.pixel_y_i       = 9'd16;
      sb_if.visible_range_i = 1'b1;
      sb_if.rgb_i           = 3'b010;

      #2;
      check("reset rgb_o", 32'(sb_if.rgb_o), 32'd0);
      check("reset pc_score", 32'(sb_if.pc_score_o), 32'd0);
      check("reset player_score", 32'(sb_if.player_score_o), 32'd0);
      check("reset game_over", 32'(sb_if.game_over_o), 32'd0);
      check("reset winner", 32'(sb_if.winner_o), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tick_cnt = '0;

      for (int i = 0; i < 17; i++) do_tick(tv[i], $sformatf("tick_vec%0d", i));

      @(negedge clk);
      sb_if.ball_x_i = 10'd0;
      repeat (5) @(negedge clk);
      check("no tick hold player_score", 32'(sb_if.player_score_o), 32'd0);
      do_tick(tk(10'd0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0), "held armed goal");

      do_tick(tk(10'd320, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0), "restart before win run");
      for (int i = 1; i <= 9; i++) begin
         do_tick(tk(10'd320, 1'b0, 4'd0, 4'(i - 1), 1'b0, 1'b0), $sformatf("rearm%0d", i));
         do_tick(tk(10'd0, 1'b0, 4'd0, 4'(i), i == 9, 1'b1), $sformatf("player goal%0d", i));
      end
      do_tick(tk(10'd320, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1), "over centre");
      do_tick(tk(10'd0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1), "over goal ignored");

      for (int i = 0; i < 40; i++) begin
         do_tick(tk(10'd320, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1), $sformatf("blink tick%0d", i));
         pix_chk(px(10'd344, 9'd16, 1'b1, 3'b010, tick_cnt[4] ? 3'b010 : 3'b111),
                 $sformatf("blink pixel%0d", i));
      end

      do_tick(tk(10'd0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0), "restart from over");
      do_tick(tk(10'd0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0), "score after restart");

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         sb_if.pixel_x_i       = pv[i].x;
         sb_if.pixel_y_i       = pv[i].y;
         sb_if.visible_range_i = pv[i].vis;
         sb_if.rgb_i           = pv[i].rgb;
         pq.push_back(pv[i].exp);
         @(posedge clk);
         #1;
         check($sformatf("pix_vec%0d rgb_o", i), 32'(sb_if.rgb_o), 32'(pq.pop_front()));
      end

      do_tick(tk(10'd320, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0), "restart before reset test");
      for (int i = 1; i <= 3; i++) begin
         do_tick(tk(10'd320, 1'b0, 4'(i - 1), 4'd0, 1'b0, 1'b0), $sformatf("pc rearm%0d", i));
         do_tick(tk(10'd700, 1'b0, 4'(i), 4'd0, 1'b0, 1'b0), $sformatf("pc goal%0d", i));
      end
      for (int i = 1; i <= 5; i++) begin
         do_tick(tk(10'd320, 1'b0, 4'd3, 4'(i - 1), 1'b0, 1'b0), $sformatf("pl rearm%0d", i));
         do_tick(tk(10'd0, 1'b0, 4'd3, 4'(i), 1'b0, 1'b0), $sformatf("pl goal%0d", i));
      end
      pix_chk(px(10'd280, 9'd16, 1'b1, 3'b010, 3'b111), "pre-reset lit pixel");
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async reset rgb_o", 32'(sb_if.rgb_o), 32'd0);
      check("async reset pc_score", 32'(sb_if.pc_score_o), 32'd0);
      check("async reset player_score", 32'(sb_if.player_score_o), 32'd0);
      check("async reset game_over", 32'(sb_if.game_over_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick_cnt = '0;
      do_tick(tk(10'd0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0), "score after reset release");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
